// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH programmable clock-enable dividers with tick and square-wave outputs.
// Defining MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN adds a sync input that realigns all channel phases.
module multi_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = 9999,
  parameter logic SQ_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, div_act, div_shd;
    logic tick_r, sq_r, wr, wrap;
    assign wr = cfg_we && cfg_ch == CH_W'(i);
    assign wrap = cnt == div_act;
    assign tick[i] = tick_r;
    assign sq[i] = sq_r;
    // div_act is only reloaded from the shadow at a wrap, so a period is never cut short
    always_ff @(posedge clk)
      if (!rst) begin
        cnt <= '0;
        tick_r <= 1'b0;
        sq_r <= SQ_INIT;
        div_act <= DEF_DIV;
        div_shd <= DEF_DIV;
      end
`ifdef MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN
      else if (sync) begin
        cnt <= '0;
        tick_r <= 1'b0;
        sq_r <= SQ_INIT;
        div_act <= div_shd;
        if (wr) div_shd <= cfg_div;
      end
`endif
      else begin
        if (wr) div_shd <= cfg_div;
        tick_r <= en[i] && wrap;
        if (wr && !en[i]) begin
          div_act <= cfg_div;
          cnt <= '0;
        end else if (en[i]) begin
          cnt <= wrap ? '0 : cnt + 1'b1;
          if (wrap) begin
            sq_r <= ~sq_r;
            div_act <= div_shd;
          end
        end
      end
  end
endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Parametrised successor to the single-rate clock divider: NUM_CH independent divider channels driven from the master clock (clk).
- Each channel produces a one-cycle enable strobe (tick) and a square wave (sq).
- Each channel's divisor is runtime-programmable through a simple write port, with glitch-free update at the channel's wrap boundary.
- Feeds the seven-segment scan, pixel-enable and debounce logic as clock-enables, so no derived clocks are needed.

Parameters:
- NUM_CH, 4: number of divider channels (1..16).
- CH_W, 2: width of the channel-select field; 2**CH_W >= NUM_CH.
- CNT_W, 32: counter and divisor width.
- DEF_DIV, 9999: divisor loaded into every channel at reset. Tick rate = f_clk/(DEF_DIV+1).
- SQ_INIT, 1: reset/resync level of every sq output.

Ports:
- clk  in  1  master clock (100 MHz).
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- en  in  NUM_CH  per-channel count enable.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  channel addressed by the write.
- cfg_div  in  CNT_W  new divisor value D; channel period = D+1 cycles.
- tick  out  NUM_CH  registered one-cycle strobe per channel.
- sq  out  NUM_CH  registered square wave per channel; period 2*(D+1) cycles, 50% duty.
- sync  in  1  only when PHASE_SYNC_EN is defined.

Behaviour:

Per-channel state:
- cnt[CNT_W], div_act[CNT_W], div_shd[CNT_W], tick, sq.

Reset (rst==0 at a posedge):
- cnt=0, tick=0, sq=SQ_INIT, div_act=div_shd=DEF_DIV, for every channel.
- Reset overrides all other inputs.

Counting, channel i, en[i]==1:
- If cnt==div_act: cnt<=0, tick<=1, sq<=~sq, div_act<=div_shd.
- Else: cnt<=cnt+1, tick<=0, sq holds.

Disabled, en[i]==0:
- cnt and sq hold; tick<=0.
- Re-enabling resumes from the held cnt.

Timing:
- With div_act=N and en held high from cnt=0, tick is high in the cycle following the (N+1)th enabled edge, then every N+1 cycles.
- sq toggles on the same edges that set tick.

Divisor write (cfg_we==1 and cfg_ch<NUM_CH):
- div_shd[cfg_ch]<=cfg_div.
- If that channel has en==0 in the same cycle, also div_act<=cfg_div and cnt<=0 (immediate apply, no stale count).
- If enabled, the new value takes effect at the next wrap.
- A write on the same cycle as that channel's wrap: the wrap loads the pre-write div_shd; the new value applies at the following wrap.
- cfg_ch>=NUM_CH: write ignored, no state change.
- cfg_we==0: cfg_ch and cfg_div are ignored.

Boundary values:
- D==0: tick high every enabled cycle; sq toggles every cycle.
- D==2**CNT_W-1: cnt reaches all-ones, then wraps to 0 with tick; there is no intermediate overflow.

Independence:
- Channels share no state except the write bus. Simultaneous wraps on several channels are all honoured.

Reset mid-operation:
- Next cycle matches the post-reset state exactly.
- Any pending shadow value is discarded and replaced by DEF_DIV.

Optional Feature:
- Macro: MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN.
- Defined: input sync exists. When sync==1 (and rst==1), every channel sets cnt<=0, tick<=0, sq<=SQ_INIT and div_act<=div_shd, regardless of en. This aligns the phase of all channels.
- Priority: reset > sync > divisor write > counting. A write in the same cycle as sync updates div_shd only; the sync loads the pre-write div_shd.
- Not defined: sync port absent; behaviour otherwise identical.

Test Plan:
- Reset, NUM_CH=4, DEF_DIV=3, en=4'b1111 -> each tick bit high 1 cycle in every 4; first tick 4 cycles after en; sq toggles on those edges; period 8 cycles.
- en[1]=0 at cnt=2, hold 10 cycles, re-enable -> tick[1] resumes exactly 2 cycles later; sq[1] unchanged during the hold.
- Channel 0 running with D=3; write cfg_ch=0, cfg_div=7 mid-period -> current period stays 4 cycles, following periods 8 cycles. The same write issued on the wrap cycle -> one more 4-cycle period, then 8.
- Write cfg_ch=2, cfg_div=0 while en[2]=0, then enable -> tick[2] constantly high, sq[2] toggles every cycle. Write cfg_ch=3 with NUM_CH=3 -> no change.
- Drive rst=0 for 1 cycle mid-count with all channels at mixed divisors -> the following cycle shows cnt=0, tick=0, sq=SQ_INIT, divisors back to DEF_DIV.
- With MULTI_CLOCK_DIVIDER_PHASE_SYNC_EN: channels at D=3 and D=5, arbitrary phases; pulse sync -> both restart from 0, tick[0] 4 and tick[1] 6 cycles later, simultaneous ticks every 12 cycles.
